// File: rtl/frame_ring_ctrl_pkg.sv
// Shared constants, FSM encoding and small helpers for the optical-flow frame ring.
package of_params;

  localparam int NUM_FRAMES   = 7;
  localparam int IMAGE_WIDTH  = 316;
  localparam int IMAGE_HEIGHT = 252;
  localparam int PIXEL_WIDTH  = 8;
  localparam int ADDR_WIDTH   = 17;
  localparam int SLOT_WIDTH   = 3;
  localparam int NUM_SLOTS    = NUM_FRAMES + 1;
  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FILL_WIDTH   = $clog2(NUM_FRAMES + 1);
  localparam int ORDER_WIDTH  = SLOT_WIDTH * NUM_FRAMES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PENDING = 2'd2
  } state_e;

  // One-hot BRAM write enable for a slot index.
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_WIDTH-1:0] slot);
    logic [NUM_SLOTS-1:0] oh;
    oh       = '0;
    oh[slot] = 1'b1;
    return oh;
  endfunction

  // Power-up read order: field i holds slot i, leaving slot NUM_FRAMES as the free write slot.
  function automatic logic [ORDER_WIDTH-1:0] init_order();
    logic [ORDER_WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      o[i*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(i);
    end
    return o;
  endfunction

endpackage

// File: rtl/frame_ring_ctrl_capture_addr_gen.sv
// Linear pixel address generator for frame capture. The address of the pixel being
// accepted is combinational (0 when in_sof restarts the frame), and the counter holds
// the address the next non-sof pixel will use. last_o flags the final pixel of a frame.
module capture_addr_gen #(
  parameter int ADDR_WIDTH   = 17,
  parameter int FRAME_PIXELS = 79632
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic                  sof_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  logic [ADDR_WIDTH-1:0] count_q, count_d;

  // Current pixel address, last-pixel detect and next counter value; only accepted pixels advance.
  always_comb begin
    addr_o  = sof_i ? '0 : count_q;
    last_o  = accept_i && (addr_o == LAST_ADDR);
    count_d = count_q;
    if (accept_i) begin
      count_d = addr_o + ADDR_WIDTH'(1);
    end
  end

  // Pixel counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_ring_ctrl.sv
// Frame ring sequencer: captures live video into the single free BRAM slot and, once a
// frame is complete, commits it as the newest entry at the next display vsync fall so
// the NUM_FRAMES slots being read by optical-flow calc never change mid-frame.
//
// Input handshake: in_valid is a one-way strobe with no back-pressure (there is no ready).
// A pixel is consumed on a rising PixelClk edge where in_valid=1 and the FSM is in CAPTURE,
// or in IDLE with in_sof=1. In PENDING every pixel is dropped on the floor.
module frame_ring_ctrl
  import of_params::NUM_FRAMES, of_params::PIXEL_WIDTH, of_params::ADDR_WIDTH,
         of_params::SLOT_WIDTH, of_params::NUM_SLOTS, of_params::FILL_WIDTH,
         of_params::ORDER_WIDTH, of_params::state_e, of_params::IDLE,
         of_params::CAPTURE, of_params::PENDING, of_params::slot_onehot,
         of_params::init_order;
#(
  parameter int IMAGE_WIDTH  = of_params::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = of_params::IMAGE_HEIGHT
) (
  input  logic                   PixelClk,
  input  logic                   rst,
  input  logic                   in_sof,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   disp_vsync,
  output logic [NUM_SLOTS-1:0]   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] wr_data,
  output logic [ORDER_WIDTH-1:0] rd_order,
  output logic                   of_enable,
  output logic                   frame_drop,
  output logic                   short_frame,
  output logic [1:0]             dbg_state,
  output logic [SLOT_WIDTH-1:0]  dbg_wr_slot,
  output logic [FILL_WIDTH-1:0]  dbg_filled
);

  localparam int                    FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [FILL_WIDTH-1:0] FILL_MAX     = FILL_WIDTH'(NUM_FRAMES);
  localparam logic [SLOT_WIDTH-1:0] FREE_SLOT    = SLOT_WIDTH'(NUM_FRAMES);

  state_e                 state_q, state_d;
  logic                   vsync_q;
  logic [SLOT_WIDTH-1:0]  wr_slot_q, wr_slot_d;
  logic [ORDER_WIDTH-1:0] rd_order_q, rd_order_d;
  logic [FILL_WIDTH-1:0]  filled_q, filled_d;
  logic                   of_enable_q, of_enable_d;
  logic                   frame_drop_q, frame_drop_d;
  logic                   short_frame_q, short_frame_d;
  logic [NUM_SLOTS-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                   accept;
  logic                   commit;
  logic                   pix_last;
  logic [ADDR_WIDTH-1:0]  pix_addr;

  // Pixel acceptance and vsync-fall commit decode shared by the FSM and the datapath.
  always_comb begin
    accept = in_valid && (((state_q == IDLE) && in_sof) || (state_q == CAPTURE));
    commit = (state_q == PENDING) && !disp_vsync && vsync_q;
  end

  capture_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_addr_gen (
    .clk     (PixelClk),
    .rst     (rst),
    .accept_i(accept),
    .sof_i   (in_sof),
    .addr_o  (pix_addr),
    .last_o  (pix_last)
  );

  // FSM state register.
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a frame starts on sof, ends on its last pixel, and waits for vsync to commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = pix_last ? PENDING : CAPTURE;
      CAPTURE: if (pix_last) state_d = PENDING;
      PENDING: if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: BRAM write port, ring rotation on commit, and sticky error flags.
  always_comb begin
    wr_en_d       = '0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_order_d    = rd_order_q;
    wr_slot_d     = wr_slot_q;
    filled_d      = filled_q;
    short_frame_d = short_frame_q | ((state_q == CAPTURE) && in_valid && in_sof);
    frame_drop_d  = frame_drop_q | ((state_q == PENDING) && in_sof);

    if (accept) begin
      wr_en_d   = slot_onehot(wr_slot_q);
      wr_addr_d = pix_addr;
      wr_data_d = in_pixel;
    end

    // The newest frame enters field 0; the oldest field falls out and becomes the next free slot.
    if (commit) begin
      rd_order_d = {rd_order_q[ORDER_WIDTH-SLOT_WIDTH-1:0], wr_slot_q};
      wr_slot_d  = rd_order_q[ORDER_WIDTH-1 -: SLOT_WIDTH];
      filled_d   = (filled_q == FILL_MAX) ? filled_q : filled_q + FILL_WIDTH'(1);
    end

    of_enable_d = (filled_d == FILL_MAX);
  end

  // Datapath and ring registers; reset discards any partially captured frame.
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      vsync_q       <= 1'b1;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_order_q    <= init_order();
      wr_slot_q     <= FREE_SLOT;
      filled_q      <= '0;
      of_enable_q   <= 1'b0;
      frame_drop_q  <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      vsync_q       <= disp_vsync;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_order_q    <= rd_order_d;
      wr_slot_q     <= wr_slot_d;
      filled_q      <= filled_d;
      of_enable_q   <= of_enable_d;
      frame_drop_q  <= frame_drop_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_order    = rd_order_q;
  assign of_enable   = of_enable_q;
  assign frame_drop  = frame_drop_q;
  assign short_frame = short_frame_q;
  assign dbg_state   = state_q;
  assign dbg_wr_slot = wr_slot_q;
  assign dbg_filled  = filled_q;

endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Bench for frame_ring_ctrl using a reduced 8x4 image so whole frames stay short.
module tb_frame_ring_ctrl;

  localparam int NF = 7;
  localparam int SW = 3;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int FP = IW * IH;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = 8'h00;
  logic        disp_vsync = 1'b1;
  logic [7:0]  wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic [20:0] rd_order;
  logic        of_enable, frame_drop, short_frame;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_wr_slot;
  logic [2:0]  dbg_filled;

  frame_ring_ctrl #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
    .PixelClk   (clk),
    .rst        (rst),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .disp_vsync (disp_vsync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_order   (rd_order),
    .of_enable  (of_enable),
    .frame_drop (frame_drop),
    .short_frame(short_frame),
    .dbg_state  (dbg_state),
    .dbg_wr_slot(dbg_wr_slot),
    .dbg_filled (dbg_filled)
  );

  // scoreboard: {slot, addr, data} of each write the model predicts
  logic [27:0] exp_q[$];
  logic [27:0] mon_e;
  int n_vec  = 0;
  int n_miss = 0;

  // reference model of the ring
  int          m_state;
  logic [16:0] m_addr;
  int          m_slot;
  int          m_order[NF];
  int          m_filled;
  logic        m_drop, m_short, m_vsq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_addr   = '0;
    m_slot   = NF;
    for (int i = 0; i < NF; i++) m_order[i] = i;
    m_filled = 0;
    m_drop   = 1'b0;
    m_short  = 1'b0;
    m_vsq    = 1'b1;
  endtask

  // write monitor: every predicted write must appear one cycle after its pixel, and no others
  always @(negedge clk) begin
    if (!rst && (wr_en != '0 || exp_q.size() != 0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(wr_en), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_en",   32'(wr_en),   32'(8'h01 << mon_e[27:25]));
        chk("wr_addr", 32'(wr_addr), 32'(mon_e[24:8]));
        chk("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
      end
    end
  end

  // driver: apply one cycle of inputs and advance the model through the same clock edge
  task automatic drive(input logic sof, input logic valid, input logic [7:0] pix, input logic vs);
    logic [16:0] a;
    int oldest;
    @(negedge clk);
    #1;
    in_sof = sof; in_valid = valid; in_pixel = pix; disp_vsync = vs;
    if (m_state == 2 && sof) m_drop = 1'b1;
    if (m_state == 1 && valid && sof) m_short = 1'b1;
    if (valid && (m_state == 1 || (m_state == 0 && sof))) begin
      a = sof ? 17'd0 : m_addr;
      exp_q.push_back({3'(m_slot), a, pix});
      m_addr  = a + 17'd1;
      m_state = (32'(a) == FP - 1) ? 2 : 1;
    end else if (m_state == 2 && !vs && m_vsq) begin
      oldest = m_order[NF-1];
      for (int i = NF - 1; i > 0; i--) m_order[i] = m_order[i-1];
      m_order[0] = m_slot;
      m_slot     = oldest;
      if (m_filled < NF) m_filled++;
      m_state = 0;
    end
    m_vsq = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic pix_drive(input logic sof);
    drive(sof, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic send_frame(input int gap);
    for (int a = 0; a < FP; a++) begin
      pix_drive(a == 0);
      if (a < 6) begin
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'b0, 8'h00, 1'b1);
          chk("gap_addr_hold", 32'(wr_addr), 32'(a));
        end
      end
    end
  endtask

  task automatic vsync_fall();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_all(input string tag);
    logic [20:0] eo;
    eo = '0;
    for (int i = 0; i < NF; i++) eo[i*SW +: SW] = 3'(m_order[i]);
    chk({tag, "/rd_order"},    32'(rd_order),    32'(eo));
    chk({tag, "/wr_slot"},     32'(dbg_wr_slot), 32'(m_slot));
    chk({tag, "/filled"},      32'(dbg_filled),  32'(m_filled));
    chk({tag, "/of_enable"},   32'(of_enable),   32'(m_filled == NF));
    chk({tag, "/frame_drop"},  32'(frame_drop),  32'(m_drop));
    chk({tag, "/short_frame"}, 32'(short_frame), 32'(m_short));
    chk({tag, "/state"},       32'(dbg_state),   32'(m_state));
  endtask

  task automatic check_perm(input string tag);
    logic [7:0] seen;
    seen = '0;
    for (int i = 0; i < NF; i++) seen[rd_order[i*SW +: SW]] = 1'b1;
    seen[dbg_wr_slot] = 1'b1;
    chk({tag, "/slot_perm"}, 32'(seen), 32'hFF);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "/wr_en"},   32'(wr_en),   32'h0);
    chk({tag, "/wr_addr"}, 32'(wr_addr), 32'h0);
    chk({tag, "/wr_data"}, 32'(wr_data), 32'h0);
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_sof = 1'b0; in_valid = 1'b0; in_pixel = 8'h00; disp_vsync = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check_reset_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // one full frame lands in slot 7, committed at vsync fall
    send_frame(0);
    check_all("t1_pending");
    vsync_fall();
    check_all("t1_commit");
    chk("t1_newest", 32'(rd_order[2:0]), 32'd7);
    chk("t1_wr_slot", 32'(dbg_wr_slot), 32'd6);

    // fill the ring: of_enable rises on the seventh commit
    for (int f = 2; f <= NF; f++) begin
      send_frame(0);
      vsync_fall();
      check_all($sformatf("t2_commit%0d", f));
      check_perm($sformatf("t2_commit%0d", f));
    end
    chk("t2_of_enable", 32'(of_enable), 32'd1);

    // valid gaps: address holds across idle cycles
    send_frame(3);
    vsync_fall();
    check_all("t6_commit");
    check_perm("t6");

    // restart mid-capture: short_frame set, same slot, no commit on vsync during capture
    for (int a = 0; a < 10; a++) pix_drive(a == 0);
    pix_drive(1'b1);
    check_all("t3_restart");
    vsync_fall();
    check_all("t3_no_commit");
    for (int a = 1; a < FP; a++) pix_drive(1'b0);
    check_all("t3_pending");
    vsync_fall();
    check_all("t3_commit");

    // sof while pending: dropped, nothing written until after commit
    send_frame(0);
    pix_drive(1'b1);
    for (int a = 0; a < 4; a++) pix_drive(1'b0);
    check_all("t4_drop");
    vsync_fall();
    for (int a = 0; a < 3; a++) pix_drive(1'b0);
    check_all("t4_idle_ignore");
    // commit and sof on the same edge
    send_frame(0);
    drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int a = 0; a < 3; a++) pix_drive(1'b0);
    check_all("t4_commit_sof");
    check_perm("t4");

    // reset mid-capture restores the power-up ring
    for (int a = 0; a < 20; a++) pix_drive(a == 0);
    apply_reset("t5_reset");
    send_frame(0);
    vsync_fall();
    check_all("t5_after");

    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
